// File: rtl/pll_dyn_cfg_ctrl.sv
// HDMI PLL dynamic-reconfiguration sequencer: applies divider/duty/phase settings,
// runs the power-down/reset sequence, waits for stable lock with retries and supervises lock.
module pll_dyn_cfg_ctrl #(
    parameter int unsigned PWD_CYCLES    = 10,
    parameter int unsigned RST_CYCLES    = 10,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT  = 1000,
    parameter int unsigned MAX_RETRY     = 2,
    localparam int unsigned DIV_W        = 10,
    localparam int unsigned PH_W         = 13
) (
    input  logic             clk_tb,
    input  logic             rst_n,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_idiv,
    input  logic [DIV_W-1:0] cfg_fdiv,
    input  logic [DIV_W-1:0] cfg_odiv0,
    input  logic [DIV_W-1:0] cfg_duty0,
    input  logic [PH_W-1:0]  cfg_phase0,
    output logic             cfg_ack,
    output logic [DIV_W-1:0] dyn_idiv,
    output logic [DIV_W-1:0] dyn_fdiv,
    output logic [DIV_W-1:0] dyn_odiv0,
    output logic [DIV_W-1:0] dyn_duty0,
    output logic [PH_W-1:0]  dyn_phase0,
    output logic             pll_pwd,
    output logic             pll_rst,
    input  logic             pll_lock,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             err,
    output logic [1:0]       retry_cnt,
    output logic [7:0]       lock_loss_cnt
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > PWD_CYCLES) ?
        ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES) :
        ((PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES);
    localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;
    localparam int unsigned STB_W = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PWD, S_RST, S_WAIT_LOCK, S_LOCKED, S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [STB_W-1:0] stab_cnt, stab_nxt;
    logic [1:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             accept_c;
    logic             lock_meta, lock_s;

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_nxt;
    end

    // Accept is taken while cfg_ack is low; the ack cycle itself launches PWD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stab_nxt  = stab_cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        accept_c  = 1'b0;
        case (state)
            S_IDLE, S_ERR: begin
                if (cfg_ack)      state_nxt = S_PWD;
                else if (cfg_req) accept_c  = 1'b1;
            end
            S_LOCKED: begin
                if (cfg_ack) begin
                    state_nxt = S_PWD;
                end else begin
                    if (cfg_req) accept_c = 1'b1;
                    if (!lock_s) begin
                        if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
                        if (!cfg_req) begin
                            state_nxt = S_RST;
                            retry_nxt = 2'd0;
                        end
                    end
                end
            end
            S_PWD: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(PWD_CYCLES - 1)) state_nxt = S_RST;
            end
            S_RST: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_nxt  = cnt + 1'b1;
                stab_nxt = lock_s ? stab_cnt + 1'b1 : '0;
                if (lock_s && (stab_cnt == STB_W'(STABLE_CYCLES - 1))) begin
                    state_nxt = S_LOCKED;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    if (retry_cnt < 2'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = S_RST;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            default: state_nxt = S_RST;
        endcase
        if (accept_c) retry_nxt = 2'd0;
        if (state_nxt != state) begin
            cnt_nxt  = '0;
            stab_nxt = '0;
        end
    end

    // Registered outputs decoded from the next state so they align with the state register
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            stab_cnt      <= '0;
            retry_cnt     <= 2'd0;
            lock_loss_cnt <= 8'd0;
            cfg_ack       <= 1'b0;
            pll_pwd       <= 1'b0;
            pll_rst       <= 1'b1;
            busy          <= 1'b1;
            locked        <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            dyn_idiv      <= DIV_W'(2);
            dyn_fdiv      <= DIV_W'(32);
            dyn_odiv0     <= DIV_W'(100);
            dyn_duty0     <= DIV_W'(100);
            dyn_phase0    <= PH_W'(16);
        end else begin
            cnt           <= cnt_nxt;
            stab_cnt      <= stab_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            cfg_ack       <= accept_c;
            pll_pwd       <= (state_nxt == S_PWD);
            pll_rst       <= (state_nxt == S_RST) || (state_nxt == S_ERR);
            busy          <= !((state_nxt == S_IDLE) || (state_nxt == S_LOCKED) ||
                               (state_nxt == S_ERR));
            locked        <= (state_nxt == S_LOCKED);
            done          <= (state_nxt == S_LOCKED) && (state != S_LOCKED);
            err           <= (state_nxt == S_ERR) && (state != S_ERR);
            if (cfg_ack) begin
                dyn_idiv   <= cfg_idiv;
                dyn_fdiv   <= cfg_fdiv;
                dyn_odiv0  <= cfg_odiv0;
                dyn_duty0  <= cfg_duty0;
                dyn_phase0 <= cfg_phase0;
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Directed bench for pll_dyn_cfg_ctrl: lock-up, reconfiguration, retries/error,
// lock glitch filtering, lock loss and mid-sequence reset.
module tb_pll_dyn_cfg_ctrl;

    logic        clk_tb = 1'b0;
    logic        rst_n;
    logic        cfg_req;
    logic [9:0]  cfg_idiv, cfg_fdiv, cfg_odiv0, cfg_duty0;
    logic [12:0] cfg_phase0;
    logic        cfg_ack;
    logic [9:0]  dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0;
    logic [12:0] dyn_phase0;
    logic        pll_pwd, pll_rst, pll_lock;
    logic        busy, locked, done, err;
    logic [1:0]  retry_cnt;
    logic [7:0]  lock_loss_cnt;

    logic        model_en = 1'b1;
    logic        lock_drv = 1'b0;
    logic [9:0]  lk_cnt   = 10'd0;

    int n_chk = 0;
    int n_bad = 0;

    pll_dyn_cfg_ctrl dut (
        .clk_tb        (clk_tb),
        .rst_n         (rst_n),
        .cfg_req       (cfg_req),
        .cfg_idiv      (cfg_idiv),
        .cfg_fdiv      (cfg_fdiv),
        .cfg_odiv0     (cfg_odiv0),
        .cfg_duty0     (cfg_duty0),
        .cfg_phase0    (cfg_phase0),
        .cfg_ack       (cfg_ack),
        .dyn_idiv      (dyn_idiv),
        .dyn_fdiv      (dyn_fdiv),
        .dyn_odiv0     (dyn_odiv0),
        .dyn_duty0     (dyn_duty0),
        .dyn_phase0    (dyn_phase0),
        .pll_pwd       (pll_pwd),
        .pll_rst       (pll_rst),
        .pll_lock      (pll_lock),
        .busy          (busy),
        .locked        (locked),
        .done          (done),
        .err           (err),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_tb = ~clk_tb;

    // PLL model: locks 50 cycles after both pll_pwd and pll_rst are low
    always @(posedge clk_tb) begin
        if (pll_rst || pll_pwd)  lk_cnt <= 10'd0;
        else if (lk_cnt != 10'd1023) lk_cnt <= lk_cnt + 10'd1;
    end
    assign pll_lock = model_en ? (lk_cnt >= 10'd50) : lock_drv;

    task automatic tick();
        @(posedge clk_tb);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [9:0] idv, input logic [9:0] fdv, input logic [9:0] odv,
                           input logic [9:0] dty, input logic [12:0] ph);
        cfg_idiv   = idv;
        cfg_fdiv   = fdv;
        cfg_odiv0  = odv;
        cfg_duty0  = dty;
        cfg_phase0 = ph;
    endtask

    // Raise cfg_req, expect ack on the next edge, hold through the ack cycle, then drop
    task automatic request(input string tag);
        cfg_req = 1'b1;
        tick();
        chk({tag, "_ack"}, 32'(cfg_ack), 32'd1);
        tick();
        chk({tag, "_ack_pulse"}, 32'(cfg_ack), 32'd0);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, both, wait_n, err_in, max_retry, ndone;
        rst_n   = 1'b0;
        cfg_req = 1'b0;
        set_cfg(10'd0, 10'd0, 10'd0, 10'd0, 13'd0);

        // 1: reset values, then lock-up with defaults
        #12;
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_pll_pwd", 32'(pll_pwd), 32'd0);
        chk("rst_idiv", 32'(dyn_idiv), 32'd2);
        chk("rst_fdiv", 32'(dyn_fdiv), 32'd32);
        chk("rst_odiv0", 32'(dyn_odiv0), 32'd100);
        chk("rst_duty0", 32'(dyn_duty0), 32'd100);
        chk("rst_phase0", 32'(dyn_phase0), 32'd16);
        chk("rst_outs", {26'd0, cfg_ack, locked, done, err, retry_cnt}, 32'd0);
        chk("rst_loss", 32'(lock_loss_cnt), 32'd0);
        #8 rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 50) begin
            n++;
            tick();
        end
        chk("t1_rst_len", n, 32'd10);
        wait_done("t1", 200);
        chk("t1_odiv0", 32'(dyn_odiv0), 32'd100);
        chk("t1_retry", 32'(retry_cnt), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: reconfigure from LOCKED
        set_cfg(10'd3, 10'd40, 10'd200, 10'd200, 13'd100);
        cfg_req = 1'b1;
        tick();
        chk("t2_ack", 32'(cfg_ack), 32'd1);
        chk("t2_odiv_old", 32'(dyn_odiv0), 32'd100);
        tick();
        cfg_req = 1'b0;
        chk("t2_ack_pulse", 32'(cfg_ack), 32'd0);
        chk("t2_odiv_new", 32'(dyn_odiv0), 32'd200);
        chk("t2_duty_new", 32'(dyn_duty0), 32'd200);
        chk("t2_phase_new", 32'(dyn_phase0), 32'd100);
        n = 0;
        both = 0;
        while (pll_pwd && n < 50) begin
            if (pll_rst) both++;
            n++;
            tick();
        end
        chk("t2_pwd_len", n, 32'd10);
        n = 0;
        while (pll_rst && n < 50) begin
            if (pll_pwd) both++;
            n++;
            tick();
        end
        chk("t2_rst_len", n, 32'd10);
        chk("t2_pwd_rst_overlap", both, 32'd0);
        wait_done("t2", 200);
        chk("t2_loss", 32'(lock_loss_cnt), 32'd0);

        // 3: lock never arrives -> two retries then error
        lock_drv = 1'b1;
        model_en = 1'b0;
        set_cfg(10'd4, 10'd44, 10'd80, 10'd50, 13'd200);
        request("t3_req");
        lock_drv = 1'b0;
        n = 0;
        wait_n = 0;
        err_in = 0;
        max_retry = 0;
        while (busy && n < 5000) begin
            if (!pll_pwd && !pll_rst) wait_n++;
            if (err) err_in++;
            if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
            n++;
            tick();
        end
        chk("t3_wait_cycles", wait_n, 32'd3000);
        chk("t3_err_early", err_in, 32'd0);
        chk("t3_max_retry", max_retry, 32'd2);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_retry", 32'(retry_cnt), 32'd2);
        repeat (5) tick();
        chk("t3_err_pulse", 32'(err), 32'd0);
        chk("t3_rst_held", 32'(pll_rst), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        set_cfg(10'd5, 10'd50, 10'd120, 10'd60, 13'd300);
        request("t3_rereq");
        chk("t3_retry_clr", 32'(retry_cnt), 32'd0);
        chk("t3_odiv", 32'(dyn_odiv0), 32'd120);

        // 4: 2-cycle lock glitch is rejected, stable lock declared after 2+4 cycles
        n = 0;
        while (!(busy && !pll_pwd && !pll_rst) && n < 100) begin
            n++;
            tick();
        end
        chk("t4_in_wait", 32'(busy && !pll_pwd && !pll_rst), 32'd1);
        lock_drv = 1'b1;
        tick();
        tick();
        lock_drv = 1'b0;
        ndone = 0;
        repeat (8) begin
            tick();
            if (done) ndone++;
        end
        chk("t4_glitch_done", ndone, 32'd0);
        lock_drv = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("t4_lock_latency", n, 32'd6);
        chk("t4_locked", 32'(locked), 32'd1);

        // 5: lock loss re-sequences without touching dyn_*
        tick();
        lock_drv = 1'b0;
        n = 0;
        while (locked && n < 10) begin
            tick();
            n++;
        end
        chk("t5_loss_latency", n, 32'd3);
        chk("t5_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        chk("t5_rst", 32'(pll_rst), 32'd1);
        chk("t5_odiv_kept", 32'(dyn_odiv0), 32'd120);
        lock_drv = 1'b1;
        wait_done("t5_relock", 100);
        set_cfg(10'd6, 10'd60, 10'd150, 10'd70, 13'd400);
        lock_drv = 1'b0;
        tick();
        tick();
        request("t5_sim_req");
        chk("t5_loss_cnt2", 32'(lock_loss_cnt), 32'd2);
        chk("t5_pwd", 32'(pll_pwd), 32'd1);
        chk("t5_odiv_new", 32'(dyn_odiv0), 32'd150);

        // 6: request while busy is ignored; async reset mid-PWD
        cfg_req = 1'b1;
        ndone = 0;
        repeat (3) begin
            tick();
            if (cfg_ack) ndone++;
        end
        chk("t6_busy_ack", ndone, 32'd0);
        chk("t6_still_pwd", 32'(pll_pwd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_pwd", 32'(pll_pwd), 32'd0);
        chk("t6_rst", 32'(pll_rst), 32'd1);
        chk("t6_odiv", 32'(dyn_odiv0), 32'd100);
        chk("t6_phase", 32'(dyn_phase0), 32'd16);
        chk("t6_loss", 32'(lock_loss_cnt), 32'd0);
        cfg_req = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (pll_rst && n < 50) begin
            n++;
            tick();
        end
        chk("t6_rst_len", n, 32'd10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
